// File: rtl/vdp_defs.sv
// Shared definitions for the VDP CPU port: command codes, register indices,
// mode encodings, FSM state types and the display-mode decode helper.
package vdp_defs;

  localparam int unsigned NUM_VDP_REGS = 11;
  localparam int unsigned ADDR_W       = 14;
  localparam int unsigned DATA_W       = 8;

  // Register indices driving the video stage
  localparam int unsigned REG_MODE0   = 0;
  localparam int unsigned REG_MODE1   = 1;
  localparam int unsigned REG_NAME    = 2;
  localparam int unsigned REG_COLOR   = 3;
  localparam int unsigned REG_FONT    = 4;
  localparam int unsigned REG_SATTR   = 5;
  localparam int unsigned REG_SPAT    = 6;
  localparam int unsigned REG_COLORS  = 7;
  localparam int unsigned REG_XSCROLL = 8;
  localparam int unsigned REG_YSCROLL = 9;

  // Command code carried in bits 7:6 of the second control byte
  typedef enum logic [1:0] {
    CODE_RD   = 2'd0,
    CODE_WR   = 2'd1,
    CODE_REG  = 2'd2,
    CODE_CRAM = 2'd3
  } code_t;

  typedef enum logic [2:0] {
    MODE_TEXT = 3'd0,
    MODE_G1   = 3'd1,
    MODE_G2   = 3'd2,
    MODE_MC   = 3'd3,
    MODE_4    = 3'd4
  } mode_t;

  // Two-byte control latch phase
  typedef enum logic {
    CTL_FIRST  = 1'b0,
    CTL_SECOND = 1'b1
  } ctl_state_t;

  // Read-ahead phases: strobe cycle, then capture of VRAM data
  typedef enum logic [1:0] {
    PF_IDLE = 2'd0,
    PF_REQ  = 2'd1,
    PF_CAP  = 2'd2
  } pf_state_t;

  // Mode select with M4 taking precedence over M1, then M2, then M3
  function automatic mode_t decode_mode(input logic m1, input logic m2,
                                        input logic m3, input logic m4);
    if (m4)      return MODE_4;
    else if (m1) return MODE_TEXT;
    else if (m2) return MODE_G2;
    else if (m3) return MODE_MC;
    else         return MODE_G1;
  endfunction

endpackage

// File: rtl/vdp_status_latch.sv
// Sticky VDP status flags.
// Ports: clk/reset; interrupt_flag (edge-detected), sprite_collision and
// too_many_sprites (level) from the video stage; sprite5 captured with OVR;
// clear = control-port read; status = {F, OVR, COL, s5}.
module vdp_status_latch
  import vdp_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       interrupt_flag,
  input  logic       sprite_collision,
  input  logic       too_many_sprites,
  input  logic [4:0] sprite5,
  input  logic       clear,
  output logic [7:0] status
);

  logic       irq_prev;
  logic       flag_f;
  logic       flag_ovr;
  logic       flag_col;
  logic [4:0] s5_q;

  // A set event in the clearing cycle survives the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev <= 1'b0;
      flag_f   <= 1'b0;
      flag_ovr <= 1'b0;
      flag_col <= 1'b0;
      s5_q     <= '0;
    end else begin
      irq_prev <= interrupt_flag;
      flag_f   <= (interrupt_flag & ~irq_prev) | (flag_f & ~clear);
      flag_ovr <= too_many_sprites | (flag_ovr & ~clear);
      flag_col <= sprite_collision | (flag_col & ~clear);
      if (too_many_sprites) s5_q <= sprite5;
    end
  end

  assign status = {flag_f, flag_ovr, flag_col, s5_q};

endmodule

// File: rtl/vdp_port.sv
// CPU-facing front end of the VDP.
// Ports: clk/reset; CPU bus (cpu_port, cpu_wr, cpu_rd, cpu_din, cpu_dout);
// VRAM CPU port (vga_addr, vga_din, vga_wr, vga_rd, vga_dout); palette write
// port (cram_wr, cram_addr, cram_din); mode, table addresses, colour and
// scroll outputs to the video stage; status event inputs from the video stage.
module vdp_port
  import vdp_defs::*;
#(
  parameter int unsigned NUM_REGS = NUM_VDP_REGS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_port,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic [13:0] vga_addr,
  output logic [7:0]  vga_din,
  output logic        vga_wr,
  output logic        vga_rd,
  input  logic [7:0]  vga_dout,
  output logic        cram_wr,
  output logic [4:0]  cram_addr,
  output logic [5:0]  cram_din,
  output logic [2:0]  mode,
  output logic [13:0] name_table_addr,
  output logic [13:0] color_table_addr,
  output logic [13:0] font_addr,
  output logic [13:0] sprite_attr_addr,
  output logic [13:0] sprite_pattern_table_addr,
  output logic        video_on,
  output logic        vert_retrace_int,
  output logic        sprite_large,
  output logic        sprite_enlarged,
  output logic [3:0]  text_color,
  output logic [3:0]  back_color,
  output logic [7:0]  x_scroll,
  output logic [7:0]  y_scroll,
  input  logic        interrupt_flag,
  input  logic        sprite_collision,
  input  logic        too_many_sprites,
  input  logic [4:0]  sprite5
);

  ctl_state_t        ctl_q, ctl_d;
  pf_state_t         pf_q, pf_d;
  code_t             code_q, code_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_cur;
  logic [DATA_W-1:0] read_buf_q, read_buf_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic [13:0] vga_addr_d;
  logic [7:0]  vga_din_d;
  logic        vga_wr_d, vga_rd_d, cram_wr_d;
  logic [4:0]  cram_addr_d;
  logic [5:0]  cram_din_d;
  logic        reg_we;
  logic [3:0]  reg_idx;
  logic        start_pf;
  logic [7:0]  status_byte;

  vdp_status_latch u_status (
    .clk              (clk),
    .reset            (reset),
    .interrupt_flag   (interrupt_flag),
    .sprite_collision (sprite_collision),
    .too_many_sprites (too_many_sprites),
    .sprite5          (sprite5),
    .clear            (cpu_rd & cpu_port),
    .status           (status_byte)
  );

  assign cpu_dout = cpu_port ? status_byte : read_buf_q;

  // Command decode, pointer update and read-ahead sequencing
  always_comb begin
    ctl_d       = ctl_q;
    pf_d        = (pf_q == PF_REQ) ? PF_CAP : PF_IDLE;
    code_d      = code_q;
    // The capture cycle's increment is folded in so a strobe landing on it sees the updated pointer
    ptr_cur     = (pf_q == PF_CAP) ? ptr_q + 14'd1 : ptr_q;
    ptr_d       = ptr_cur;
    read_buf_d  = (pf_q == PF_CAP) ? vga_dout : read_buf_q;
    vga_addr_d  = vga_addr;
    vga_din_d   = vga_din;
    vga_wr_d    = 1'b0;
    vga_rd_d    = 1'b0;
    cram_wr_d   = 1'b0;
    cram_addr_d = cram_addr;
    cram_din_d  = cram_din;
    reg_we      = 1'b0;
    reg_idx     = cpu_din[3:0];
    start_pf    = 1'b0;

    if (cpu_wr && cpu_port) begin
      if (ctl_q == CTL_FIRST) begin
        ptr_d = {ptr_cur[13:8], cpu_din};
        ctl_d = CTL_SECOND;
      end else begin
        code_d = code_t'(cpu_din[7:6]);
        ptr_d  = {cpu_din[5:0], ptr_cur[7:0]};
        ctl_d  = CTL_FIRST;
        case (code_t'(cpu_din[7:6]))
          CODE_RD:  start_pf = 1'b1;
          CODE_REG: reg_we   = (32'(cpu_din[3:0]) < NUM_REGS);
          default:  ;
        endcase
      end
    end else if (cpu_wr) begin
      ctl_d      = CTL_FIRST;
      read_buf_d = cpu_din;
      ptr_d      = ptr_cur + 14'd1;
      if (code_q == CODE_CRAM) begin
        cram_wr_d   = 1'b1;
        cram_addr_d = ptr_cur[4:0];
        cram_din_d  = cpu_din[5:0];
      end else begin
        vga_wr_d   = 1'b1;
        vga_addr_d = ptr_cur;
        vga_din_d  = cpu_din;
      end
    end else if (cpu_rd) begin
      ctl_d = CTL_FIRST;
      if (!cpu_port) start_pf = 1'b1;
    end

    // Read-ahead: strobe now, capture two edges later and advance the pointer then
    if (start_pf) begin
      vga_rd_d   = 1'b1;
      vga_addr_d = ptr_d;
      pf_d       = PF_REQ;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl_q      <= CTL_FIRST;
      pf_q       <= PF_IDLE;
      code_q     <= CODE_RD;
      ptr_q      <= '0;
      read_buf_q <= '0;
      vga_addr   <= '0;
      vga_din    <= '0;
      vga_wr     <= 1'b0;
      vga_rd     <= 1'b0;
      cram_wr    <= 1'b0;
      cram_addr  <= '0;
      cram_din   <= '0;
    end else begin
      ctl_q      <= ctl_d;
      pf_q       <= pf_d;
      code_q     <= code_d;
      ptr_q      <= ptr_d;
      read_buf_q <= read_buf_d;
      vga_addr   <= vga_addr_d;
      vga_din    <= vga_din_d;
      vga_wr     <= vga_wr_d;
      vga_rd     <= vga_rd_d;
      cram_wr    <= cram_wr_d;
      cram_addr  <= cram_addr_d;
      cram_din   <= cram_din_d;
    end
  end

  // Register file; code-2 writes take the latched low pointer byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[reg_idx] <= ptr_cur[7:0];
    end
  end

  mode_t       mode_c;
  logic [13:0] name_c, color_c, font_c, sattr_c, spat_c;

  // Table base decode; mode 2 and mode 4 coarsen the address granularity
  always_comb begin
    mode_c  = decode_mode(regs_q[REG_MODE1][4], regs_q[REG_MODE0][1],
                          regs_q[REG_MODE1][3], regs_q[REG_MODE0][2]);
    name_c  = {regs_q[REG_NAME][3:0], 10'b0};
    color_c = {regs_q[REG_COLOR], 6'b0};
    font_c  = {regs_q[REG_FONT][2:0], 11'b0};
    sattr_c = {regs_q[REG_SATTR][6:0], 7'b0};
    spat_c  = {regs_q[REG_SPAT][2:0], 11'b0};
    if (mode_c == MODE_G2) begin
      color_c = {regs_q[REG_COLOR][7], 13'b0};
      font_c  = {regs_q[REG_FONT][2], 13'b0};
    end else if (mode_c == MODE_4) begin
      name_c  = {regs_q[REG_NAME][3:1], 11'b0};
      sattr_c = {regs_q[REG_SATTR][6:1], 8'b0};
      spat_c  = {regs_q[REG_SPAT][2], 13'b0};
      font_c  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode                      <= 3'(MODE_G1);
      name_table_addr           <= '0;
      color_table_addr          <= '0;
      font_addr                 <= '0;
      sprite_attr_addr          <= '0;
      sprite_pattern_table_addr <= '0;
      video_on                  <= 1'b0;
      vert_retrace_int          <= 1'b0;
      sprite_large              <= 1'b0;
      sprite_enlarged           <= 1'b0;
      text_color                <= '0;
      back_color                <= '0;
      x_scroll                  <= '0;
      y_scroll                  <= '0;
    end else begin
      mode                      <= 3'(mode_c);
      name_table_addr           <= name_c;
      color_table_addr          <= color_c;
      font_addr                 <= font_c;
      sprite_attr_addr          <= sattr_c;
      sprite_pattern_table_addr <= spat_c;
      video_on                  <= regs_q[REG_MODE1][6];
      vert_retrace_int          <= regs_q[REG_MODE1][5];
      sprite_large              <= regs_q[REG_MODE1][1];
      sprite_enlarged           <= regs_q[REG_MODE1][0];
      text_color                <= regs_q[REG_COLORS][7:4];
      back_color                <= regs_q[REG_COLORS][3:0];
      x_scroll                  <= regs_q[REG_XSCROLL];
      y_scroll                  <= regs_q[REG_YSCROLL];
    end
  end

endmodule

// File: tb/tb_vdp_port.sv
// Randomised scoreboard bench for vdp_port with a behavioural VDP model.
module tb_vdp_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_port, cpu_wr, cpu_rd;
  logic [7:0]  cpu_din, cpu_dout;
  logic [13:0] vga_addr;
  logic [7:0]  vga_din, vga_dout;
  logic        vga_wr, vga_rd, cram_wr;
  logic [4:0]  cram_addr;
  logic [5:0]  cram_din;
  logic [2:0]  mode;
  logic [13:0] name_table_addr, color_table_addr, font_addr;
  logic [13:0] sprite_attr_addr, sprite_pattern_table_addr;
  logic        video_on, vert_retrace_int, sprite_large, sprite_enlarged;
  logic [3:0]  text_color, back_color;
  logic [7:0]  x_scroll, y_scroll;
  logic        interrupt_flag, sprite_collision, too_many_sprites;
  logic [4:0]  sprite5;

  always #5 clk = ~clk;

  vdp_port dut (
    .clk(clk), .reset(reset), .cpu_port(cpu_port), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .vga_addr(vga_addr), .vga_din(vga_din),
    .vga_wr(vga_wr), .vga_rd(vga_rd), .vga_dout(vga_dout), .cram_wr(cram_wr),
    .cram_addr(cram_addr), .cram_din(cram_din), .mode(mode),
    .name_table_addr(name_table_addr), .color_table_addr(color_table_addr),
    .font_addr(font_addr), .sprite_attr_addr(sprite_attr_addr),
    .sprite_pattern_table_addr(sprite_pattern_table_addr), .video_on(video_on),
    .vert_retrace_int(vert_retrace_int), .sprite_large(sprite_large),
    .sprite_enlarged(sprite_enlarged), .text_color(text_color), .back_color(back_color),
    .x_scroll(x_scroll), .y_scroll(y_scroll), .interrupt_flag(interrupt_flag),
    .sprite_collision(sprite_collision), .too_many_sprites(too_many_sprites),
    .sprite5(sprite5)
  );

  // VRAM: synchronous, read data valid the cycle after the read strobe
  logic [7:0] vram [0:16383];
  always @(posedge clk) begin
    if (vga_wr) vram[vga_addr] <= vga_din;
    if (vga_rd) vga_dout <= vram[vga_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  // Expected bus events: kind 0 = VRAM write, 1 = VRAM read, 2 = CRAM write
  typedef struct packed {
    logic [1:0]  kind;
    logic [13:0] addr;
    logic [7:0]  data;
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_got, mon_exp;

  // Reference model state
  int         m_ptr, m_code, m_rbuf;
  bit         m_second, m_rbuf_known;
  int         m_regs[11];
  bit         m_f, m_ovr, m_col;
  int         m_s5;
  logic [7:0] ref_mem[int];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe the DUT presents must match the next expected event
  always @(negedge clk) begin
    if (!reset && (vga_wr || vga_rd || cram_wr)) begin
      mon_got.kind = vga_wr ? 2'd0 : (vga_rd ? 2'd1 : 2'd2);
      mon_got.addr = cram_wr ? {9'b0, cram_addr} : vga_addr;
      mon_got.data = vga_wr ? vga_din : (cram_wr ? {2'b0, cram_din} : 8'h00);
      if (32'(vga_wr) + 32'(vga_rd) + 32'(cram_wr) > 1) mon_got.kind = 2'd3;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL bus_event: unexpected kind %0d addr 0x%0h data 0x%0h, none required",
                 mon_got.kind, mon_got.addr, mon_got.data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          miscompares++;
          $display("FAIL bus_event: got kind %0d addr 0x%0h data 0x%0h, required kind %0d addr 0x%0h data 0x%0h",
                   mon_got.kind, mon_got.addr, mon_got.data, mon_exp.kind, mon_exp.addr, mon_exp.data);
        end
      end
    end
  end

  // CPU strobes on consecutive edges are outside the port's contract
  bit prev_strobe = 1'b0;
  always @(posedge clk) begin
    if (prev_strobe && (cpu_wr || cpu_rd)) begin
      miscompares++;
      $display("FAIL strobe_spacing: strobes on consecutive clocks");
    end
    prev_strobe <= cpu_wr | cpu_rd;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic push_ev(input int kind, input int addr, input int data);
    ev_t e;
    e.kind = 2'(kind);
    e.addr = 14'(addr);
    e.data = 8'(data);
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_code = 0; m_rbuf = 0; m_rbuf_known = 1'b1; m_second = 1'b0;
    foreach (m_regs[i]) m_regs[i] = 0;
    m_f = 0; m_ovr = 0; m_col = 0; m_s5 = 0;
  endtask

  task automatic model_prefetch();
    push_ev(1, m_ptr, 0);
    m_rbuf_known = ref_mem.exists(m_ptr);
    m_rbuf = m_rbuf_known ? int'(ref_mem[m_ptr]) : 0;
    m_ptr = (m_ptr + 1) % 16384;
  endtask

  task automatic bus_cycle(input logic port, input logic wr, input logic rd,
                           input logic [7:0] din, output logic [7:0] dout);
    @(negedge clk);
    cpu_port = port; cpu_wr = wr; cpu_rd = rd; cpu_din = din;
    #1 dout = cpu_dout;
    @(negedge clk);
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    repeat (2 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic ctrl_wr(input int b);
    logic [7:0] d;
    if (!m_second) begin
      m_ptr = (m_ptr & 'h3F00) | (b & 'hFF);
      m_second = 1'b1;
    end else begin
      m_second = 1'b0;
      m_code = (b >> 6) & 3;
      m_ptr = ((b & 'h3F) << 8) | (m_ptr & 'hFF);
      if (m_code == 0) model_prefetch();
      if (m_code == 2 && (b & 15) < 11) m_regs[b & 15] = m_ptr & 'hFF;
    end
    bus_cycle(1'b1, 1'b1, 1'b0, 8'(b), d);
  endtask

  task automatic data_wr(input int b);
    logic [7:0] d;
    m_second = 1'b0;
    if (m_code == 3) begin
      push_ev(2, m_ptr % 32, b % 64);
    end else begin
      push_ev(0, m_ptr, b);
      ref_mem[m_ptr] = 8'(b);
    end
    m_rbuf = b; m_rbuf_known = 1'b1;
    m_ptr = (m_ptr + 1) % 16384;
    bus_cycle(1'b0, 1'b1, 1'b0, 8'(b), d);
  endtask

  task automatic data_rd();
    logic [7:0] d;
    int  expv;
    bit  known;
    expv = m_rbuf; known = m_rbuf_known;
    m_second = 1'b0;
    model_prefetch();
    bus_cycle(1'b0, 1'b0, 1'b1, 8'h00, d);
    if (known) check("data_read", 128'(d), 128'(expv));
  endtask

  task automatic ctrl_rd();
    logic [7:0] d;
    int expv;
    expv = (int'(m_f) << 7) | (int'(m_ovr) << 6) | (int'(m_col) << 5) | m_s5;
    m_f = 0; m_ovr = 0; m_col = 0; m_second = 1'b0;
    bus_cycle(1'b1, 1'b0, 1'b1, 8'h00, d);
    check("status_read", 128'(d), 128'(expv));
  endtask

  task automatic pulse(input int which, input int s5v);
    @(negedge clk);
    case (which)
      0:       interrupt_flag = 1'b1;
      1:       sprite_collision = 1'b1;
      default: begin too_many_sprites = 1'b1; sprite5 = 5'(s5v); end
    endcase
    @(negedge clk);
    interrupt_flag = 1'b0; sprite_collision = 1'b0; too_many_sprites = 1'b0;
    case (which)
      0:       m_f = 1;
      1:       m_col = 1;
      default: begin m_ovr = 1; m_s5 = s5v; end
    endcase
    repeat (2) @(negedge clk);
  endtask

  // Video-stage outputs derived arithmetically from the model registers
  function automatic logic [100:0] exp_outputs();
    int r0, r1, r2, r3, r4, r5, r6, r7, md, nm, co, fo, sa, sp;
    r0 = m_regs[0]; r1 = m_regs[1]; r2 = m_regs[2]; r3 = m_regs[3];
    r4 = m_regs[4]; r5 = m_regs[5]; r6 = m_regs[6]; r7 = m_regs[7];
    if ((r0 & 4) != 0)       md = 4;
    else if ((r1 & 16) != 0) md = 0;
    else if ((r0 & 2) != 0)  md = 2;
    else if ((r1 & 8) != 0)  md = 3;
    else                     md = 1;
    nm = (r2 & 15) * 1024;
    co = r3 * 64;
    fo = (r4 & 7) * 2048;
    sa = (r5 & 127) * 128;
    sp = (r6 & 7) * 2048;
    if (md == 2) begin co = (r3 & 128) * 64; fo = (r4 & 4) * 2048; end
    if (md == 4) begin nm = (r2 & 14) * 1024; sa = (r5 & 126) * 128; sp = (r6 & 4) * 2048; fo = 0; end
    return {3'(md), 14'(nm), 14'(co), 14'(fo), 14'(sa), 14'(sp),
            r1[6], r1[5], r1[1], r1[0], 4'(r7 / 16), 4'(r7 % 16), 8'(m_regs[8]), 8'(m_regs[9])};
  endfunction

  task automatic check_outputs(input string name);
    logic [100:0] act;
    act = {mode, name_table_addr, color_table_addr, font_addr, sprite_attr_addr,
           sprite_pattern_table_addr, video_on, vert_retrace_int, sprite_large,
           sprite_enlarged, text_color, back_color, x_scroll, y_scroll};
    check(name, 128'(act), 128'(exp_outputs()));
  endtask

  task automatic peek(input logic port, output logic [7:0] v);
    @(negedge clk);
    cpu_port = port;
    #1 v = cpu_dout;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] v;
    cpu_port = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_din = 8'h00;
    interrupt_flag = 1'b0; sprite_collision = 1'b0; too_many_sprites = 1'b0; sprite5 = 5'h00;
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("reset_mode", 128'(mode), 128'(1));
    check("reset_video_on", 128'(video_on), 128'(0));
    check_outputs("reset_outputs");
    check("reset_strobes", 128'({vga_wr, vga_rd, cram_wr}), 128'(0));
    peek(1'b1, v); check("reset_status", 128'(v), 128'(8'h00));
    peek(1'b0, v); check("reset_read_buf", 128'(v), 128'(8'h00));

    // Register writes and mode 4 decode
    ctrl_wr('h60); ctrl_wr('h81);
    check("video_on", 128'({video_on, vert_retrace_int}), 128'(2'b11));
    ctrl_wr('h04); ctrl_wr('h80);
    ctrl_wr('hFF); ctrl_wr('h82);
    check("mode4", 128'(mode), 128'(4));
    check("mode4_name", 128'(name_table_addr), 128'(14'h3800));
    check_outputs("mode4_outputs");

    // VRAM writes across the pointer wrap
    ctrl_wr('hFF); ctrl_wr('h7F);
    data_wr('h11); data_wr('h22);

    // Read-ahead
    ctrl_wr('h34); ctrl_wr('h52);
    data_wr('h5A); data_wr('hA5);
    ctrl_wr('h34); ctrl_wr('h12);
    data_rd(); data_rd();

    // Palette write, no VRAM strobe
    ctrl_wr('h05); ctrl_wr('hC0);
    data_wr('h3F);

    // Status flags and clear-on-read
    pulse(0, 0); pulse(1, 0);
    ctrl_rd(); ctrl_rd();
    pulse(2, 'h13);
    ctrl_rd();

    // Control read resynchronises the byte latch
    ctrl_wr('h12); ctrl_rd();
    ctrl_wr('h34); ctrl_wr('h40);
    data_wr('h99);

    // Reset in the middle of a command pair
    ctrl_wr('h55);
    do_reset();
    check_outputs("reset_again");
    ctrl_wr('h00); ctrl_wr('h40);
    data_wr('h77);

    // Pre-fill a window around the wrap point, then random traffic
    ctrl_wr('hF8); ctrl_wr('h7F);
    for (int i = 0; i < 24; i++) data_wr(int'($urandom_range(0, 255)));
    for (int n = 0; n < 300; n++) begin
      int op, base;
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1: begin
          base = (16376 + int'($urandom_range(0, 15))) % 16384;
          if (m_second) ctrl_rd();
          ctrl_wr(base & 'hFF);
          case ($urandom_range(0, 2))
            0:       ctrl_wr((base >> 8) & 'h3F);
            1:       ctrl_wr('h40 | ((base >> 8) & 'h3F));
            default: ctrl_wr('hC0 | ((base >> 8) & 'h3F));
          endcase
        end
        2: begin
          if (m_second) ctrl_rd();
          ctrl_wr(int'($urandom_range(0, 255)));
          ctrl_wr('h80 | int'($urandom_range(0, 15)));
        end
        3, 4: data_wr(int'($urandom_range(0, 255)));
        5, 6: data_rd();
        7:    ctrl_rd();
        8:    ctrl_wr(int'($urandom_range(0, 255)));
        default: pulse(int'($urandom_range(0, 2)), int'($urandom_range(0, 31)));
      endcase
      check_outputs("random_outputs");
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
